idelay_tap_calibrator: RTL
==========================

// Module: idelay_tap_calibrator
// PURPOSE
//  Training controller for one IDELAYE2 in VAR_LOAD mode. It waits for IDELAYCTRL RDY,
//  then sweeps taps 0..31. At each tap it checks received words against a training pattern.
//  It then loads the centre of the longest error-free tap window.
//  Sits between the IDELAYCTRL/IDELAYE2 pair and the deserialiser feeding sample_word.
// PARAMETERS
//  WORD_W        8      width of sample_word / TRAIN_PATTERN
//  TRAIN_PATTERN 8'hB4  expected word during training
//  SETTLE_CYC    16     clk cycles to wait after each tap load before sampling (>=1)
//  SAMPLE_WORDS  64     valid words compared per tap (>=1)
//  MIN_WINDOW    4      minimum passing-window length (taps) for success (1..32)
//  DEFAULT_TAP   2      tap driven on delay_tap out of reset and after a failed calibration
// PORTS
//  clk          in  1       clock; also IDELAYE2 C
//  reset        in  1       synchronous, active-low reset
//  start        in  1       pulse: begin calibration (ignored while busy)
//  rdy          in  1       IDELAYCTRL RDY
//  sample_word  in  WORD_W  deserialised delayed data
//  sample_valid in  1       sample_word qualifier
//  delay_ld     out 1       IDELAYE2 LD, one-cycle pulse
//  delay_tap    out 5       IDELAYE2 CNTVALUEIN
//  busy         out 1       high from start acceptance until DONE/FAIL
//  cal_done     out 1       sticky success flag
//  cal_fail     out 1       sticky failure flag
//  best_tap     out 5       tap finally loaded
//  window_len   out 6       longest passing window length (0..32)
// BEHAVIOUR
//  Reset (reset==0 at posedge) values:
//   - delay_ld=0, delay_tap=DEFAULT_TAP, busy=0, cal_done=0, cal_fail=0,
//     best_tap=DEFAULT_TAP, window_len=0, state IDLE.
//   - Reset mid-sweep aborts with no final load.
//  FSM states:
//   - IDLE: on start go to WAIT_RDY. busy=1; cal_done, cal_fail, window_len and the
//     run trackers are cleared; tap=0.
//   - WAIT_RDY: stay until rdy=1, then go to LOAD.
//   - LOAD: 1 cycle; delay_ld=1, delay_tap=tap. Next state SETTLE.
//   - SETTLE: count SETTLE_CYC cycles; sample_valid is ignored. Next state CHECK.
//   - CHECK: count SAMPLE_WORDS cycles with sample_valid=1.
//     Any sample_word!=TRAIN_PATTERN marks the tap failed. Cycles with
//     sample_valid=0 do not count, and there is no timeout. Next state EVAL.
//   - EVAL: 1 cycle, run-length update:
//     * pass: cur_len++; cur_start=tap if cur_len was 0.
//     * fail: cur_len=0.
//     * best update: if the updated cur_len > best_len (strict; the first longest
//       window wins ties), set best_len=cur_len, best_start=cur_start.
//     * tap<31: tap++, go to LOAD.
//     * tap==31: go to CENTER (no wrap from 31 to 0; windows never wrap).
//   - CENTER: 1 cycle.
//     * best_len>=MIN_WINDOW: best_tap = best_start + (best_len-1)>>1 (floor);
//       delay_ld=1, delay_tap=best_tap; go to DONE.
//     * otherwise: best_tap=DEFAULT_TAP; delay_ld=1 with DEFAULT_TAP; go to FAIL.
//     * window_len=best_len in both cases.
//   - DONE/FAIL: busy=0; cal_done (DONE) or cal_fail (FAIL) held;
//     delay_tap held; return to IDLE immediately.
//  Other rules:
//   - rdy deasserts in LOAD..EVAL: restart from WAIT_RDY with tap=0 and run trackers
//     cleared. delay_ld is not asserted in that cycle.
//   - start while busy is ignored. start in the same cycle as reset is lost.
//   - delay_tap changes only in LOAD/CENTER cycles or on reset; between loads it holds the last loaded tap.
//   - Arithmetic: tap is a 5-bit count; cur_len/best_len are 6-bit (max 32); centre fits 5 bits.
//   - Nominal duration with continuous valid: 32*(1+SETTLE_CYC+SAMPLE_WORDS+1)+1 cycles after rdy.
// TESTING
//  1. Reset held, then released -> delay_tap=2, busy=0, all flags 0, no delay_ld pulse.
//  2. Words pass only at taps 10..19, rdy=1, valid always -> 33 delay_ld pulses;
//     cal_done=1, window_len=10, best_tap=14, delay_tap=14.
//  3. Passing taps 3..6 and 20..23 (tie) -> best_tap=4, window_len=4, cal_done=1.
//  4. Passing taps 0..2 only (MIN_WINDOW=4) -> cal_fail=1, window_len=3, delay_tap=2.
//  5. rdy dropped at tap 7 then restored -> sweep restarts at tap 0;
//     final result matches scenario 2.
//  6. reset pulsed during CHECK of tap 12, start reissued, and start pulsed while busy
//     -> outputs at reset values; the extra start is ignored; one clean 33-load sweep.

Source files
------------

// File: rtl/idelay_tap_calibrator.sv
// Training controller for one IDELAYE2 used in VAR_LOAD mode.
// It waits for IDELAYCTRL RDY and then sweeps taps 0..31. At each tap it compares
// received words against a training pattern. Finally it loads the centre of the longest
// error-free tap window. If that window is shorter than MIN_WINDOW, it loads DEFAULT_TAP.
//
// Ports:
//   clk_i          clock (also drives IDELAYE2 C)
//   reset_ni       synchronous active-low reset
//   start_i        pulse: begin calibration (ignored while busy)
//   rdy_i          IDELAYCTRL RDY
//   sample_word_i  deserialised delayed data
//   sample_valid_i sample_word_i qualifier
//   delay_ld_o     IDELAYE2 LD, one-cycle pulse
//   delay_tap_o    IDELAYE2 CNTVALUEIN, holds the last loaded tap
//   busy_o         high from start acceptance until DONE/FAIL
//   cal_done_o     sticky success flag
//   cal_fail_o     sticky failure flag
//   best_tap_o     tap finally loaded
//   window_len_o   longest passing window length (0..32)
//
// All outputs are registered. The LD pulse and the new tap value appear in the cycle
// that follows the LOAD or CENTER state.
module idelay_tap_calibrator #(
   parameter int unsigned       WORD_W        = 8,
   parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'hB4,
   parameter int unsigned       SETTLE_CYC    = 16,
   parameter int unsigned       SAMPLE_WORDS  = 64,
   parameter int unsigned       MIN_WINDOW    = 4,
   parameter logic [4:0]        DEFAULT_TAP   = 5'd2
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic              rdy_i,
   input  logic [WORD_W-1:0] sample_word_i,
   input  logic              sample_valid_i,
   output logic              delay_ld_o,
   output logic [4:0]        delay_tap_o,
   output logic              busy_o,
   output logic              cal_done_o,
   output logic              cal_fail_o,
   output logic [4:0]        best_tap_o,
   output logic [5:0]        window_len_o
);

   typedef enum logic [3:0] {
      StIdle, StWaitRdy, StLoad, StSettle, StCheck, StEval, StCenter, StDone, StFail
   } state_e;

   state_e      state_q;
   logic [15:0] cnt_q;
   logic [4:0]  tap_q;
   logic        fail_q;
   logic [5:0]  cur_len_q, best_len_q;
   logic [4:0]  cur_start_q, best_start_q;
   logic        delay_ld_q, busy_q, cal_done_q, cal_fail_q;
   logic [4:0]  delay_tap_q, best_tap_q;
   logic [5:0]  window_len_q;

   // Run-length update for the tap just checked.
   logic       tap_pass;
   logic [5:0] new_len;
   logic [4:0] new_start;
   logic [5:0] centre;
   logic       sweeping;

   always_comb begin
      tap_pass  = ~fail_q;
      new_len   = tap_pass ? cur_len_q + 6'd1 : 6'd0;
      new_start = (tap_pass && cur_len_q == 6'd0) ? tap_q : cur_start_q;
      centre    = {1'b0, best_start_q} + ((best_len_q - 6'd1) >> 1);
      sweeping  = (state_q == StLoad) || (state_q == StSettle) ||
                  (state_q == StCheck) || (state_q == StEval);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         tap_q        <= '0;
         fail_q       <= 1'b0;
         cur_len_q    <= '0;
         cur_start_q  <= '0;
         best_len_q   <= '0;
         best_start_q <= '0;
         delay_ld_q   <= 1'b0;
         delay_tap_q  <= DEFAULT_TAP;
         busy_q       <= 1'b0;
         cal_done_q   <= 1'b0;
         cal_fail_q   <= 1'b0;
         best_tap_q   <= DEFAULT_TAP;
         window_len_q <= '0;
      end else begin
         delay_ld_q <= 1'b0;
         if (sweeping && !rdy_i) begin
            // Losing RDY invalidates every tap measured so far, so the sweep restarts.
            state_q      <= StWaitRdy;
            cnt_q        <= '0;
            tap_q        <= '0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start_i) begin
                     state_q      <= StWaitRdy;
                     busy_q       <= 1'b1;
                     cal_done_q   <= 1'b0;
                     cal_fail_q   <= 1'b0;
                     window_len_q <= '0;
                     cnt_q        <= '0;
                     tap_q        <= '0;
                     cur_len_q    <= '0;
                     cur_start_q  <= '0;
                     best_len_q   <= '0;
                     best_start_q <= '0;
                  end
               end
               StWaitRdy: begin
                  if (rdy_i) state_q <= StLoad;
               end
               StLoad: begin
                  delay_ld_q  <= 1'b1;
                  delay_tap_q <= tap_q;
                  fail_q      <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= StSettle;
               end
               StSettle: begin
                  if (cnt_q == 16'(SETTLE_CYC - 1)) begin
                     cnt_q   <= '0;
                     state_q <= StCheck;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
               StCheck: begin
                  if (sample_valid_i) begin
                     if (sample_word_i != TRAIN_PATTERN) fail_q <= 1'b1;
                     if (cnt_q == 16'(SAMPLE_WORDS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StEval;
                     end else begin
                        cnt_q <= cnt_q + 16'd1;
                     end
                  end
               end
               StEval: begin
                  cur_len_q   <= new_len;
                  cur_start_q <= new_start;
                  // Strict compare: the first of equally long windows is kept.
                  if (new_len > best_len_q) begin
                     best_len_q   <= new_len;
                     best_start_q <= new_start;
                  end
                  if (tap_q == 5'd31) begin
                     state_q <= StCenter;
                  end else begin
                     tap_q   <= tap_q + 5'd1;
                     state_q <= StLoad;
                  end
               end
               StCenter: begin
                  delay_ld_q   <= 1'b1;
                  busy_q       <= 1'b0;
                  window_len_q <= best_len_q;
                  if (best_len_q >= 6'(MIN_WINDOW)) begin
                     best_tap_q  <= centre[4:0];
                     delay_tap_q <= centre[4:0];
                     cal_done_q  <= 1'b1;
                     state_q     <= StDone;
                  end else begin
                     best_tap_q  <= DEFAULT_TAP;
                     delay_tap_q <= DEFAULT_TAP;
                     cal_fail_q  <= 1'b1;
                     state_q     <= StFail;
                  end
               end
               StDone, StFail: state_q <= StIdle;
               default:        state_q <= StIdle;
            endcase
         end
      end
   end

   assign delay_ld_o   = delay_ld_q;
   assign delay_tap_o  = delay_tap_q;
   assign busy_o       = busy_q;
   assign cal_done_o   = cal_done_q;
   assign cal_fail_o   = cal_fail_q;
   assign best_tap_o   = best_tap_q;
   assign window_len_o = window_len_q;

endmodule
